// File: rtl/fft_peak_detect_if.sv
// Streaming bin input and per-frame peak result bus for fft_peak_detect.
// The master side feeds bins and accepts results; the slave side is the detector.
interface fft_peak_detect_if #(
  parameter int M = 3,
  parameter int W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_re;
  logic signed [W-1:0]  in_im;
  logic                 in_last;
  logic                 pk_valid;
  logic                 pk_ready;
  logic [M-1:0]         pk_bin;
  logic [2*W-1:0]       pk_mag;
  logic [2*W+M-1:0]     pk_energy;
  logic                 frame_err;

  modport master (
    output in_valid, in_re, in_im, in_last, pk_ready,
    input  in_ready, pk_valid, pk_bin, pk_mag, pk_energy, frame_err
  );

  modport slave (
    input  in_valid, in_re, in_im, in_last, pk_ready,
    output in_ready, pk_valid, pk_bin, pk_mag, pk_energy, frame_err
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Per-frame peak finder for FFT bins: magnitude-squared, running max and energy,
// one result per well-formed frame; frames with a misplaced in_last are dropped.
module fft_peak_detect #(
  parameter int N = 8,
  parameter int M = 3,
  parameter int W = 16
) (
  input  logic              clk,
  input  logic              rst,
  fft_peak_detect_if.slave  bus
);
  localparam int EW = 2*W + M;
  localparam logic [M-1:0] LAST_IDX = M'(N-1);

  typedef enum logic [0:0] {ACC = 1'b0, HOLD = 1'b1} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic [M-1:0]    r_cnt;
  logic            r_s1_valid;
  logic            r_s1_last;
  logic            r_s1_err;
  logic [M-1:0]    r_s1_bin;
  logic [2*W-1:0]  r_s1_mag;
  logic [2*W-1:0]  r_max;
  logic [M-1:0]    r_max_bin;
  logic [EW-1:0]   r_energy;
  logic            r_pk_valid;
  logic [M-1:0]    r_pk_bin;
  logic [2*W-1:0]  r_pk_mag;
  logic [EW-1:0]   r_pk_energy;
  logic            r_frame_err;

  logic            w_accept;
  logic [2*W-1:0]  w_re_sq;
  logic [2*W-1:0]  w_im_sq;
  logic [2*W-1:0]  w_mag;
  logic            w_err;
  logic            w_first;
  logic            w_take;
  logic [2*W-1:0]  w_nxt_max;
  logic [M-1:0]    w_nxt_bin;
  logic [EW-1:0]   w_nxt_energy;
  logic            w_frame_done;

  assign w_accept = bus.in_valid && r_in_ready;
  // Signed operands, 2W-wide context: each square is non-negative and the sum tops out at 2^(2W-1).
  assign w_re_sq  = bus.in_re * bus.in_re;
  assign w_im_sq  = bus.in_im * bus.in_im;
  assign w_mag    = w_re_sq + w_im_sq;
  assign w_err    = bus.in_last != (r_cnt == LAST_IDX);

  // Bin 0 seeds the frame unconditionally; later bins win only on a strict increase.
  assign w_first      = (r_s1_bin == {M{1'b0}});
  assign w_take       = w_first || (r_s1_mag > r_max);
  assign w_nxt_max    = w_take ? r_s1_mag : r_max;
  assign w_nxt_bin    = w_take ? r_s1_bin : r_max_bin;
  assign w_nxt_energy = (w_first ? {EW{1'b0}} : r_energy) + {{M{1'b0}}, r_s1_mag};
  assign w_frame_done = r_s1_valid && r_s1_last && !r_s1_err;

  assign bus.in_ready  = r_in_ready;
  assign bus.pk_valid  = r_pk_valid;
  assign bus.pk_bin    = r_pk_bin;
  assign bus.pk_mag    = r_pk_mag;
  assign bus.pk_energy = r_pk_energy;
  assign bus.frame_err = r_frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= {M{1'b0}};
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_bin   <= {M{1'b0}};
      r_s1_mag   <= {(2*W){1'b0}};
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_mag  <= w_mag;
        r_s1_bin  <= r_cnt;
        r_s1_last <= bus.in_last;
        r_s1_err  <= w_err;
        r_cnt     <= w_err ? {M{1'b0}} : r_cnt + M'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ACC;
      r_in_ready  <= 1'b0;
      r_max       <= {(2*W){1'b0}};
      r_max_bin   <= {M{1'b0}};
      r_energy    <= {EW{1'b0}};
      r_pk_valid  <= 1'b0;
      r_pk_bin    <= {M{1'b0}};
      r_pk_mag    <= {(2*W){1'b0}};
      r_pk_energy <= {EW{1'b0}};
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_s1_valid && r_s1_err) begin
        r_max       <= {(2*W){1'b0}};
        r_max_bin   <= {M{1'b0}};
        r_energy    <= {EW{1'b0}};
        r_frame_err <= 1'b1;
      end else if (r_s1_valid) begin
        r_max     <= w_nxt_max;
        r_max_bin <= w_nxt_bin;
        r_energy  <= w_nxt_energy;
      end else begin
        r_max <= r_max;
      end
      // A bin left in stage 1 when HOLD starts is bin 0 of the next frame, so HOLD never sees w_frame_done.
      case (r_state)
        ACC: begin
          if (w_frame_done) begin
            r_state     <= HOLD;
            r_in_ready  <= 1'b0;
            r_pk_valid  <= 1'b1;
            r_pk_bin    <= w_nxt_bin;
            r_pk_mag    <= w_nxt_max;
            r_pk_energy <= w_nxt_energy;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        HOLD: begin
          if (r_pk_valid && bus.pk_ready) begin
            r_state    <= ACC;
            r_pk_valid <= 1'b0;
            r_in_ready <= 1'b1;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_state    <= ACC;
          r_pk_valid <= 1'b0;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end
endmodule
